// File: rtl/decodificador_tecla_if.sv
// Keypad decoder bus: row/column inputs from the scanner and the decoded key outputs.
interface decodificador_tecla_if;
    logic [3:0] fila;
    logic [3:0] col;
    logic [3:0] tecla;
    logic       tecla_valida;
    logic       tecla_presionada;

    modport master (
        output fila,
        output col,
        input  tecla,
        input  tecla_valida,
        input  tecla_presionada
    );

    modport slave (
        input  fila,
        input  col,
        output tecla,
        output tecla_valida,
        output tecla_presionada
    );
endinterface

// File: rtl/decodificador_tecla.sv
// Keypad decoder: per-frame key detection, frame-level debounce and one-clk key strobe.
// Define KEY_REPEAT_EN to add auto-repeat strobes every REPEAT_FRAMES frames while held.
module decodificador_tecla #(
    parameter int DEB_FRAMES    = 3,
    parameter int REPEAT_FRAMES = 8
) (
    input logic            clk,
    input logic            rst_n,
    decodificador_tecla_if.slave bus
);

    typedef enum logic [1:0] {
        REPOSO,
        CONFIRMA,
        PRESIONADA,
        SUELTA
    } estado_t;

    localparam logic [3:0] DEB = 4'(DEB_FRAMES);

    if ((DEB_FRAMES < 2) || (DEB_FRAMES > 15) || (REPEAT_FRAMES < 1)) begin : g_param_check
        $error("decodificador_tecla: DEB_FRAMES must be 2..15 and REPEAT_FRAMES >= 1");
    end

    function automatic logic es_one_hot(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

    // Bit 3 is index 0 for both rows and columns.
    function automatic logic [1:0] indice(input logic [3:0] v);
        logic [1:0] idx;
        case (v)
            4'b1000: idx = 2'd0;
            4'b0100: idx = 2'd1;
            4'b0010: idx = 2'd2;
            default: idx = 2'd3;
        endcase
        return idx;
    endfunction

    logic [3:0] fila_s1, fs, fs_prev;
    logic [3:0] col_s1, cs;

    // Synchronisers idle at the frame-gap pattern so reset release never looks like a frame end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fila_s1 <= 4'hF;
            fs      <= 4'hF;
            fs_prev <= 4'hF;
            col_s1  <= 4'h0;
            cs      <= 4'h0;
        end else begin
            fila_s1 <= bus.fila;
            fs      <= fila_s1;
            fs_prev <= fs;
            col_s1  <= bus.col;
            cs      <= col_s1;
        end
    end

    logic       frame_end;
    logic       muestra;
    logic [3:0] codigo_muestra;
    logic       acc_hit, acc_multi;
    logic [3:0] acc_code;

    assign frame_end      = (fs == 4'hF) && (fs_prev != 4'hF);
    assign muestra        = es_one_hot(fs) && (cs != 4'd0);
    assign codigo_muestra = {indice(fs), indice(cs)};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_hit   <= 1'b0;
            acc_multi <= 1'b0;
            acc_code  <= 4'd0;
        end else if (frame_end) begin
            acc_hit   <= 1'b0;
            acc_multi <= 1'b0;
            acc_code  <= 4'd0;
        end else if (muestra) begin
            if (!es_one_hot(cs) || (acc_hit && (acc_code != codigo_muestra))) begin
                acc_multi <= 1'b1;
            end else begin
                acc_hit  <= 1'b1;
                acc_code <= codigo_muestra;
            end
        end
    end

    logic res_none, res_one;
    assign res_none = !acc_hit && !acc_multi;
    assign res_one  = acc_hit && !acc_multi;

    estado_t    estado, estado_next;
    logic [3:0] cnt, cnt_next;
    logic [3:0] cand, cand_next;
    logic [3:0] tecla_q, tecla_next;
    logic       valida_q, valida_next;
    logic       presionada_q, presionada_next;

`ifdef KEY_REPEAT_EN
    localparam int             REP_W   = $clog2(REPEAT_FRAMES + 1);
    localparam logic [REP_W-1:0] REP_MAX = REP_W'(REPEAT_FRAMES);
    logic [REP_W-1:0] rep_cnt, rep_next;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado       <= REPOSO;
            cnt          <= 4'd0;
            cand         <= 4'd0;
            tecla_q      <= 4'd0;
            valida_q     <= 1'b0;
            presionada_q <= 1'b0;
`ifdef KEY_REPEAT_EN
            rep_cnt      <= '0;
`endif
        end else begin
            estado       <= estado_next;
            cnt          <= cnt_next;
            cand         <= cand_next;
            tecla_q      <= tecla_next;
            valida_q     <= valida_next;
            presionada_q <= presionada_next;
`ifdef KEY_REPEAT_EN
            rep_cnt      <= rep_next;
`endif
        end
    end

    always_comb begin
        estado_next = estado;
        cnt_next    = cnt;
        cand_next   = cand;
        if (frame_end) begin
            case (estado)
                REPOSO: begin
                    if (res_one) begin
                        cand_next   = acc_code;
                        cnt_next    = 4'd1;
                        estado_next = CONFIRMA;
                    end
                end
                CONFIRMA: begin
                    if (res_one && (acc_code == cand)) begin
                        cnt_next = cnt + 4'd1;
                        if (cnt + 4'd1 == DEB) begin
                            estado_next = PRESIONADA;
                        end
                    end else if (res_one) begin
                        cand_next = acc_code;
                        cnt_next  = 4'd1;
                    end else begin
                        cnt_next    = 4'd0;
                        estado_next = REPOSO;
                    end
                end
                PRESIONADA: begin
                    if (res_none) begin
                        cnt_next    = 4'd1;
                        estado_next = SUELTA;
                    end
                end
                SUELTA: begin
                    if (res_none) begin
                        if (cnt + 4'd1 == DEB) begin
                            cnt_next    = 4'd0;
                            estado_next = REPOSO;
                        end else begin
                            cnt_next = cnt + 4'd1;
                        end
                    end else begin
                        estado_next = PRESIONADA;
                    end
                end
                default: estado_next = REPOSO;
            endcase
        end
    end

    logic acepta, libera;
    assign acepta = frame_end && (estado == CONFIRMA) && (estado_next == PRESIONADA);
    assign libera = frame_end && (estado == SUELTA) && (estado_next == REPOSO);

    // The key code only changes on acceptance, so it keeps the last key after release.
    always_comb begin
        tecla_next      = tecla_q;
        valida_next     = 1'b0;
        presionada_next = presionada_q;
        if (acepta) begin
            tecla_next      = cand;
            valida_next     = 1'b1;
            presionada_next = 1'b1;
        end else if (libera) begin
            presionada_next = 1'b0;
        end
`ifdef KEY_REPEAT_EN
        rep_next = rep_cnt;
        if (frame_end) begin
            if (acepta) begin
                rep_next = '0;
            end else if ((estado == PRESIONADA) && res_one && (acc_code == tecla_q)) begin
                if (rep_cnt + REP_W'(1) == REP_MAX) begin
                    valida_next = 1'b1;
                    rep_next    = '0;
                end else begin
                    rep_next = rep_cnt + REP_W'(1);
                end
            end else if (!res_one) begin
                rep_next = '0;
            end
        end
`endif
    end

    assign bus.tecla            = tecla_q;
    assign bus.tecla_valida     = valida_q;
    assign bus.tecla_presionada = presionada_q;

endmodule
